// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
//   state_e : arbiter FSM state (IDLE, GRANT)
//   NREQ    : number of requesters
//   IDXW    : width of a binary requester index
//   idx2oh  : binary index -> one-hot vector of NREQ bits
package rr_arb4_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] idx2oh(input logic [IDXW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector.
// Scans req_i starting at position ptr_i, then ptr_i+1, ptr_i+2, ptr_i+3
// (mod 4) and reports the first set bit.
//   req_i   [3:0] : request vector
//   ptr_i   [1:0] : highest-priority position for this scan
//   pick_o  [3:0] : one-hot winner, zero when no request
//   index_o [1:0] : binary index of the winner, zero when no request
//   any_o         : at least one request is set
module rr_pick
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IDXW-1:0] index_o,
  output logic            any_o
);

  logic [IDXW-1:0] cand;

  always_comb begin
    pick_o  = '0;
    index_o = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Index arithmetic wraps naturally in IDXW bits, giving the mod-4 scan.
      cand = ptr_i + IDXW'(i);
      if (!any_o && req_i[cand]) begin
        any_o   = 1'b1;
        index_o = cand;
        pick_o  = idx2oh(cand);
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with hold-until-release and a
// forced-release timeout.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   req   [3:0] : request per requester
//   done        : owner signals end of use (only looked at while granted)
//   gnt   [3:0] : one-hot grant, zero when idle
//   gnt_idx[1:0]: binary index of gnt, zero when idle
//   gnt_valid   : a grant is currently held
//   expired     : one-cycle pulse after a timeout-only release
//   state_dbg_o : current FSM state (observation only)
//   ptr_dbg_o   : current rotating priority pointer (observation only)
//
// Handshake: a requester owns the resource from the first cycle gnt_valid is
// high until the edge that samples done=1, its own req low, or the hold limit;
// outputs drop on that edge and at least one IDLE cycle follows before the
// next grant. All outputs are registered.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            expired,
  output state_e          state_dbg_o,
  output logic [IDXW-1:0] ptr_dbg_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic            expired_q, expired_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] pick;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            timeout;
  logic            owner_drop;

  rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .index_o (pick_idx),
    .any_o   (pick_any)
  );

  assign timeout    = (cnt_q == HOLD_LAST);
  assign owner_drop = !req[idx_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          gnt_d   = pick;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (done || owner_drop || timeout) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = idx_q + IDXW'(1);
          state_d = IDLE;
          // A timeout that coincides with a normal release is not reported.
          expired_d = timeout && !done && !owner_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = idx_q;
  assign gnt_valid   = valid_q;
  assign expired     = expired_q;
  assign state_dbg_o = state_q;
  assign ptr_dbg_o   = ptr_q;

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;
  import rr_arb4_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;
  state_e     state_dbg;
  logic [1:0] ptr_dbg;

  always #5 clk = ~clk;

  rr_arb4 #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .expired     (expired),
    .state_dbg_o (state_dbg),
    .ptr_dbg_o   (ptr_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                            input logic e_valid, input logic e_exp);
    check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(e_idx));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
    check({tag, ".expired"},   32'(expired),   32'(e_exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("reset.ptr", 32'(ptr_dbg), 32'd0);
    check("reset.state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;

    // Single requester, done on third grant cycle
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect_out($sformatf("t1.cyc%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      if (c == 3) done = 1'b1;
    end
    tick();
    expect_out("t1.release", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t1.ptr", 32'(ptr_dbg), 32'd1);
    done = 1'b0;
    req  = '0;

    // All requesting from ptr=0: rotation 0,1,2,3,0 with an idle cycle between
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      tick();
      expect_out($sformatf("t2.grant%0d", e), idx2oh(e), e, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      expect_out("t2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      if (exp_q.size() == 0) req = '0;
    end
    check("t2.ptr", 32'(ptr_dbg), 32'd1);

    // Timeout: held exactly 8 cycles, expired pulse, regrant after one idle
    req = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      expect_out($sformatf("t3.hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    expect_out("t3.expired", 4'b0000, 2'd0, 1'b0, 1'b1);
    check("t3.ptr", 32'(ptr_dbg), 32'd3);
    tick();
    expect_out("t3.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = '0;
    tick();
    expect_out("t3.drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner drops request; non-owner requests ignored while granted
    req = 4'b0010;
    tick();
    expect_out("t4.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    expect_out("t4.release", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t4.ptr", 32'(ptr_dbg), 32'd2);
    tick();
    expect_out("t4.own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("t4.ignore_req0", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("t4.done", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t4.ptr_wrap", 32'(ptr_dbg), 32'd0);
    done = 1'b0;
    req  = '0;

    // done coincides with timeout: normal release, no expired pulse
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("t5.valid%0d", c), 32'(gnt_valid), 32'd1);
      if (c == 8) done = 1'b1;
    end
    tick();
    expect_out("t5.release", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t5.ptr", 32'(ptr_dbg), 32'd1);
    done = 1'b0;
    req  = '0;

    // Asynchronous reset mid-grant
    req = 4'b0010;
    tick();
    expect_out("t6.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t6.ptr", 32'(ptr_dbg), 32'd0);
    check("t6.state", 32'(state_dbg), 32'(IDLE));
    req = 4'b1010;
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("t6.after", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("t6.done", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t6.ptr_after", 32'(ptr_dbg), 32'd2);
    done = 1'b0;
    req  = '0;

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
